halflife_monitor: RTL

//  Receive-side counterpart of the half-life timer: watches the timer's 1-bit output line,

---
 rtl/halflife_pkg.sv | 13 +
 rtl/halflife_sync_edge.sv | 26 ++
 rtl/halflife_monitor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/halflife_pkg.sv
// rtl/halflife_pkg.sv - shared types and constants for the half-life timer monitor
package halflife_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TOUT    = 2'd2
  } state_t;

  localparam logic [7:0] PCNT_MAX      = 8'd255;
  localparam int         CNT_W_DEFAULT = 16;

endpackage

// File: rtl/halflife_sync_edge.sv
// rtl/halflife_sync_edge.sv - multi-flop synchronizer with a one-cycle rising-edge pulse
module halflife_sync_edge #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC-1:0] sync_q;
  logic            last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], sig_in};
      last_q <= sync_q[SYNC-1];
    end
  end

  assign rise = sync_q[SYNC-1] & ~last_q;

endmodule

// File: rtl/halflife_monitor.sv
// rtl/halflife_monitor.sv - measures rise-to-rise period of the half-life timer output
// and checks it against the loaded setting; counts pulses and flags a stalled line.
module halflife_monitor
  import halflife_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = 16'hFFFF,
  parameter int SHIFT   = 4,
  parameter int TOL     = 1,
  parameter int SYNC    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  input  logic [3:0]       expected,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [7:0]       pulse_count,
  output logic             match,
  output logic             timeout
);

  localparam int               CW  = CNT_W + 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic rise;

  halflife_sync_edge #(.SYNC(SYNC)) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic             match_q, match_d;
  logic             tmo_q, tmo_d;

  // Compare one bit wider than the counter so the difference never wraps.
  logic [CW-1:0] exp_per, cnt_w, diff;
  logic          in_tol;
  logic [7:0]    pcnt_inc;

  assign exp_per  = CW'(expected) << SHIFT;
  assign cnt_w    = {1'b0, cnt_q};
  assign diff     = (cnt_w >= exp_per) ? (cnt_w - exp_per) : (exp_per - cnt_w);
  assign in_tol   = (diff <= CW'(TOL));
  assign pcnt_inc = (pcnt_q == PCNT_MAX) ? pcnt_q : (pcnt_q + 8'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    pcnt_d   = pcnt_q;
    match_d  = match_q;
    tmo_d    = tmo_q;
    if (clr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      pcnt_d   = '0;
      match_d  = 1'b0;
      tmo_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, TOUT: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
            pcnt_d  = pcnt_inc;
          end
        end
        MEASURE: begin
          // An edge on the terminal count still counts as a valid period.
          if (rise) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = CNT_W'(1);
            pcnt_d   = pcnt_inc;
            match_d  = in_tol;
          end else if (cnt_q == TMO) begin
            state_d = TOUT;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      pcnt_q   <= '0;
      match_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      pcnt_q   <= pcnt_d;
      match_q  <= match_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign pulse_count  = pcnt_q;
  assign match        = match_q;
  assign timeout      = tmo_q;

endmodule
